// File: rtl/icm_lookup_responder.sv
// ICM lookup responder: one ICM space's page table, answering fixed-latency lookups
// with map/unmap configuration and a sequential invalidate-all engine.

`ifndef ICM_ENTRY_NUM_MPT
`define ICM_ENTRY_NUM_MPT 16
`endif
`ifndef ICM_SPACE_ADDR_WIDTH
`define ICM_SPACE_ADDR_WIDTH 64
`endif
`ifndef PHY_SPACE_ADDR_WIDTH
`define PHY_SPACE_ADDR_WIDTH 64
`endif

module icm_lookup_responder #(
    parameter int ICM_ENTRY_NUM     = `ICM_ENTRY_NUM_MPT,
    parameter int ICM_ENTRY_NUM_LOG = (ICM_ENTRY_NUM > 1) ? $clog2(ICM_ENTRY_NUM) : 1,
    parameter int PAGE_SHIFT        = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             lookup_valid,
    input  logic [ICM_ENTRY_NUM_LOG-1:0]     lookup_head,
    output logic                             rsp_valid,
    output logic [`ICM_SPACE_ADDR_WIDTH-1:0] rsp_icm_addr,
    output logic [`PHY_SPACE_ADDR_WIDTH-1:0] rsp_phy_addr,
    output logic                             rsp_hit,
    input  logic                             map_valid,
    input  logic [ICM_ENTRY_NUM_LOG-1:0]     map_index,
    input  logic [`PHY_SPACE_ADDR_WIDTH-1:0] map_phy_addr,
    output logic                             map_ready,
    input  logic                             unmap_valid,
    input  logic [ICM_ENTRY_NUM_LOG-1:0]     unmap_index,
    input  logic                             flush_req,
    output logic                             flush_busy,
    output logic                             flush_done,
    output logic [31:0]                      lookup_cnt,
    output logic [31:0]                      miss_cnt
);

    localparam int ICM_W = `ICM_SPACE_ADDR_WIDTH;
    localparam int PHY_W = `PHY_SPACE_ADDR_WIDTH;
    localparam logic [ICM_ENTRY_NUM_LOG-1:0] FLUSH_LAST = ICM_ENTRY_NUM_LOG'(ICM_ENTRY_NUM - 1);
    localparam logic [PHY_W-1:0] PAGE_MASK = {PHY_W{1'b1}} << PAGE_SHIFT;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [ICM_ENTRY_NUM_LOG-1:0]   flush_ptr_q, flush_ptr_d;
    logic                           map_ready_q, map_ready_d;
    logic                           flush_busy_q, flush_busy_d;
    logic                           flush_done_q, flush_done_d;

    logic [ICM_ENTRY_NUM-1:0]       valid_q, valid_d;
    logic [PHY_W-1:0]               phy_mem_q [ICM_ENTRY_NUM];
    logic [PHY_W-1:0]               phy_mem_d [ICM_ENTRY_NUM];

    logic                           s1_valid_q, s1_valid_d;
    logic [ICM_ENTRY_NUM_LOG-1:0]   s1_head_q, s1_head_d;

    logic                           rsp_valid_q, rsp_valid_d;
    logic [ICM_W-1:0]               rsp_icm_addr_q, rsp_icm_addr_d;
    logic [PHY_W-1:0]               rsp_phy_addr_q, rsp_phy_addr_d;
    logic                           rsp_hit_q, rsp_hit_d;
    logic [31:0]                    lookup_cnt_q, lookup_cnt_d;
    logic [31:0]                    miss_cnt_q, miss_cnt_d;

    logic                           map_acc_s;
    logic                           unmap_acc_s;
    logic                           flush_clr_s;
    logic                           read_hit_s;
    logic [PHY_W-1:0]               read_phy_s;

    assign map_acc_s   = map_valid && map_ready_q;
    assign unmap_acc_s = unmap_valid && map_ready_q;
    assign flush_clr_s = (state_q == ST_FLUSH);

    // Flush sequencer; status outputs are registered from the next state.
    always_comb begin
        state_d     = state_q;
        flush_ptr_d = flush_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d     = ST_FLUSH;
                    flush_ptr_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_ptr_q == FLUSH_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    flush_ptr_d = flush_ptr_q + ICM_ENTRY_NUM_LOG'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        map_ready_d  = (state_d != ST_FLUSH);
        flush_busy_d = (state_d == ST_FLUSH);
        flush_done_d = (state_d == ST_DONE);
    end

    // Table update: unmap is applied after map so it wins on an equal index.
    always_comb begin
        valid_d   = valid_q;
        phy_mem_d = phy_mem_q;
        if (flush_clr_s) begin
            valid_d[flush_ptr_q] = 1'b0;
        end else begin
            valid_d = valid_d;
        end
        if (map_acc_s) begin
            valid_d[map_index]   = 1'b1;
            phy_mem_d[map_index] = map_phy_addr;
        end else begin
            valid_d = valid_d;
        end
        if (unmap_acc_s) begin
            valid_d[unmap_index] = 1'b0;
        end else begin
            valid_d = valid_d;
        end
    end

    // Reading the next-state table forwards same-cycle writes into the lookup.
    always_comb begin
        read_hit_s = 1'b0;
        read_phy_s = '0;
        if (s1_valid_q && !flush_clr_s) begin
            read_hit_s = valid_d[s1_head_q];
            read_phy_s = phy_mem_d[s1_head_q] & PAGE_MASK;
        end else begin
            read_hit_s = 1'b0;
            read_phy_s = '0;
        end
    end

    // Pipeline stages, response fields and saturating counters.
    always_comb begin
        s1_valid_d     = lookup_valid;
        s1_head_d      = lookup_valid ? lookup_head : s1_head_q;
        rsp_valid_d    = s1_valid_q;
        rsp_icm_addr_d = rsp_icm_addr_q;
        rsp_phy_addr_d = rsp_phy_addr_q;
        rsp_hit_d      = rsp_hit_q;
        lookup_cnt_d   = lookup_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        if (s1_valid_q) begin
            rsp_icm_addr_d = ICM_W'(s1_head_q) << PAGE_SHIFT;
            rsp_hit_d      = read_hit_s;
            rsp_phy_addr_d = read_hit_s ? read_phy_s : {PHY_W{1'b0}};
        end else begin
            rsp_hit_d = rsp_hit_q;
        end
        if (lookup_valid && (lookup_cnt_q != CNT_MAX)) begin
            lookup_cnt_d = lookup_cnt_q + 32'd1;
        end else begin
            lookup_cnt_d = lookup_cnt_q;
        end
        if (s1_valid_q && !read_hit_s && (miss_cnt_q != CNT_MAX)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Control state, valid bits, pipeline and outputs; reset drops in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            flush_ptr_q    <= '0;
            map_ready_q    <= 1'b0;
            flush_busy_q   <= 1'b0;
            flush_done_q   <= 1'b0;
            valid_q        <= '0;
            s1_valid_q     <= 1'b0;
            s1_head_q      <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_icm_addr_q <= '0;
            rsp_phy_addr_q <= '0;
            rsp_hit_q      <= 1'b0;
            lookup_cnt_q   <= 32'd0;
            miss_cnt_q     <= 32'd0;
        end else begin
            state_q        <= state_d;
            flush_ptr_q    <= flush_ptr_d;
            map_ready_q    <= map_ready_d;
            flush_busy_q   <= flush_busy_d;
            flush_done_q   <= flush_done_d;
            valid_q        <= valid_d;
            s1_valid_q     <= s1_valid_d;
            s1_head_q      <= s1_head_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_icm_addr_q <= rsp_icm_addr_d;
            rsp_phy_addr_q <= rsp_phy_addr_d;
            rsp_hit_q      <= rsp_hit_d;
            lookup_cnt_q   <= lookup_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
        end
    end

    // Address storage carries no reset; its contents only matter behind a valid bit.
    always_ff @(posedge clk) begin
        phy_mem_q <= phy_mem_d;
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_icm_addr = rsp_icm_addr_q;
    assign rsp_phy_addr = rsp_phy_addr_q;
    assign rsp_hit      = rsp_hit_q;
    assign map_ready    = map_ready_q;
    assign flush_busy   = flush_busy_q;
    assign flush_done   = flush_done_q;
    assign lookup_cnt   = lookup_cnt_q;
    assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_icm_lookup_responder.sv
// Bench for icm_lookup_responder: vector table plus directed sequences, with a
// scoreboard queue that checks every response's contents and its arrival cycle.

module tb_icm_lookup_responder;

    logic        clk;
    logic        rst_n;
    logic        lookup_valid;
    logic [3:0]  lookup_head;
    logic        rsp_valid;
    logic [63:0] rsp_icm_addr;
    logic [63:0] rsp_phy_addr;
    logic        rsp_hit;
    logic        map_valid;
    logic [3:0]  map_index;
    logic [63:0] map_phy_addr;
    logic        map_ready;
    logic        unmap_valid;
    logic [3:0]  unmap_index;
    logic        flush_req;
    logic        flush_busy;
    logic        flush_done;
    logic [31:0] lookup_cnt;
    logic [31:0] miss_cnt;

    icm_lookup_responder #(
        .ICM_ENTRY_NUM(16),
        .ICM_ENTRY_NUM_LOG(4),
        .PAGE_SHIFT(12)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid(lookup_valid), .lookup_head(lookup_head),
        .rsp_valid(rsp_valid), .rsp_icm_addr(rsp_icm_addr),
        .rsp_phy_addr(rsp_phy_addr), .rsp_hit(rsp_hit),
        .map_valid(map_valid), .map_index(map_index), .map_phy_addr(map_phy_addr),
        .map_ready(map_ready),
        .unmap_valid(unmap_valid), .unmap_index(unmap_index),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .lookup_cnt(lookup_cnt), .miss_cnt(miss_cnt)
    );

    typedef struct {
        int          due;
        logic        hit;
        logic [63:0] icm;
        logic [63:0] phy;
    } exp_t;

    typedef struct {
        logic [3:0]  idx;
        logic        map_en;
        logic        unmap_en;
        logic [63:0] addr;
        logic        exp_hit;
        logic [63:0] exp_phy;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   exp_lookups = 0;
    int   exp_misses = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: responses must arrive in order, exactly on their due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            e = sb_q.pop_front();
            chk("rsp_missing", 64'(cyc), 64'(e.due));
        end
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                e = sb_q.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.due));
                chk("rsp_hit", 64'(rsp_hit), 64'(e.hit));
                chk("rsp_icm_addr", rsp_icm_addr, e.icm);
                chk("rsp_phy_addr", rsp_phy_addr, e.phy);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        lookup_valid = 1'b0;
        map_valid    = 1'b0;
        unmap_valid  = 1'b0;
        flush_req    = 1'b0;
    endtask

    task automatic lk(input logic [3:0] h, input logic eh, input logic [63:0] ep);
        exp_t e;
        lookup_valid = 1'b1;
        lookup_head  = h;
        e.due = cyc + 2;
        e.hit = eh;
        e.icm = 64'(h) << 12;
        e.phy = ep;
        sb_q.push_back(e);
        exp_lookups++;
        if (!eh) exp_misses++;
    endtask

    task automatic mp(input logic [3:0] idx, input logic [63:0] a);
        map_valid    = 1'b1;
        map_index    = idx;
        map_phy_addr = a;
    endtask

    task automatic um(input logic [3:0] idx);
        unmap_valid = 1'b1;
        unmap_index = idx;
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_lookup_cnt"}, 64'(lookup_cnt), 64'(exp_lookups));
        chk({tag, "_miss_cnt"}, 64'(miss_cnt), 64'(exp_misses));
    endtask

    initial begin
        vecs[0] = '{4'd0,  1'b1, 1'b0, 64'h0000_0000_0001_0000, 1'b1, 64'h0000_0000_0001_0000};
        vecs[1] = '{4'd1,  1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_F000};
        vecs[2] = '{4'd2,  1'b1, 1'b0, 64'h8000_0000_0000_0ABC, 1'b1, 64'h8000_0000_0000_0000};
        vecs[3] = '{4'd3,  1'b1, 1'b0, 64'h0000_0000_DEAD_B000, 1'b1, 64'h0000_0000_DEAD_B000};
        vecs[4] = '{4'd3,  1'b1, 1'b0, 64'h0000_0000_BEEF_C000, 1'b1, 64'h0000_0000_BEEF_C000};
        vecs[5] = '{4'd2,  1'b0, 1'b1, 64'h0,                   1'b0, 64'h0};
        vecs[6] = '{4'd15, 1'b1, 1'b0, 64'h0000_0007_7777_7000, 1'b1, 64'h0000_0007_7777_7000};
        vecs[7] = '{4'd14, 1'b0, 1'b0, 64'h0,                   1'b0, 64'h0};
        vecs[8] = '{4'd15, 1'b1, 1'b1, 64'h0000_0000_0000_F000, 1'b0, 64'h0};
        vecs[9] = '{4'd2,  1'b1, 1'b0, 64'h0000_0000_0000_2000, 1'b1, 64'h0000_0000_0000_2000};

        rst_n = 1'b0;
        lookup_valid = 1'b0; lookup_head = 4'd0;
        map_valid = 1'b0; map_index = 4'd0; map_phy_addr = 64'd0;
        unmap_valid = 1'b0; unmap_index = 4'd0; flush_req = 1'b0;
        repeat (3) step();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_fields", {rsp_icm_addr | rsp_phy_addr}, 64'(0));
        chk("rst_rsp_hit", 64'(rsp_hit), 64'(0));
        chk("rst_map_ready", 64'(map_ready), 64'(0));
        chk("rst_flush_flags", 64'({flush_busy, flush_done}), 64'(0));
        chk_cnts("rst");
        rst_n = 1'b1;
        step(); step();
        chk("post_rst_map_ready", 64'(map_ready), 64'(1));

        // Basic hit, then response fields hold after the pulse.
        mp(4'd5, 64'h1_2345_6000); step();
        lk(4'd5, 1'b1, 64'h1_2345_6000); step(); step(); step();
        chk("hold_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("hold_rsp_phy", rsp_phy_addr, 64'h1_2345_6000);
        chk("hold_rsp_hit", 64'(rsp_hit), 64'(1));

        lk(4'd7, 1'b0, 64'h0); step(); step(); step();
        chk_cnts("miss");

        // Back-to-back lookups.
        lk(4'd5, 1'b1, 64'h1_2345_6000); step();
        lk(4'd7, 1'b0, 64'h0); step();
        lk(4'd5, 1'b1, 64'h1_2345_6000); step(); step(); step();
        chk_cnts("b2b");

        // Write in the read cycle is forwarded; one cycle later it is not.
        lk(4'd9, 1'b1, 64'hA000); step();
        mp(4'd9, 64'hA000); step(); step(); step();
        um(4'd9); step();
        lk(4'd9, 1'b0, 64'h0); step(); step();
        mp(4'd9, 64'hA000); step(); step(); step();
        lk(4'd9, 1'b0, 64'h0); step();
        um(4'd9); step(); step(); step();
        mp(4'd3, 64'h3000); um(4'd3); step();
        lk(4'd3, 1'b0, 64'h0); step(); step(); step();
        chk_cnts("fwd");

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].map_en) mp(vecs[i].idx, vecs[i].addr);
            if (vecs[i].unmap_en) um(vecs[i].idx);
            step();
            lk(vecs[i].idx, vecs[i].exp_hit, vecs[i].exp_phy);
            step(); step();
        end
        step();
        chk_cnts("vec");

        // Map and unmap of different entries in one cycle both apply.
        mp(4'd4, 64'h4000); um(4'd5); step();
        lk(4'd4, 1'b1, 64'h4000); step();
        lk(4'd5, 1'b0, 64'h0); step(); step(); step();

        // Flush: 16 cycles not ready, done pulse on the 17th, everything misses.
        chk("pre_flush_ready", 64'(map_ready), 64'(1));
        flush_req = 1'b1; step();
        for (int i = 0; i < 16; i++) begin
            chk("flush_map_ready", 64'(map_ready), 64'(0));
            chk("flush_busy", 64'(flush_busy), 64'(1));
            chk("flush_done_early", 64'(flush_done), 64'(0));
            if (i == 0) mp(4'd6, 64'h6000);
            if (i == 2) lk(4'd0, 1'b0, 64'h0);
            if (i == 5) flush_req = 1'b1;
            if (i == 14) lk(4'd1, 1'b0, 64'h0);
            step();
        end
        chk("flush_done_pulse", 64'(flush_done), 64'(1));
        chk("done_map_ready", 64'(map_ready), 64'(1));
        chk("done_busy", 64'(flush_busy), 64'(0));
        step();
        chk("flush_done_clear", 64'(flush_done), 64'(0));
        for (int i = 0; i < 7; i++) begin
            lk(4'(i), 1'b0, 64'h0);
            step();
        end
        step(); step();
        chk_cnts("flush");

        // Reset during a flush with a lookup in flight.
        mp(4'd0, 64'h9000); step();
        flush_req = 1'b1; step(); step(); step();
        lookup_valid = 1'b1; lookup_head = 4'd0; step();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
            step();
        end
        exp_lookups = 0;
        exp_misses = 0;
        chk_cnts("mid_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("post_rst_no_done", 64'(flush_done), 64'(0));
            step();
        end
        chk("post_rst_ready", 64'(map_ready), 64'(1));
        chk("post_rst_busy", 64'(flush_busy), 64'(0));
        lk(4'd0, 1'b0, 64'h0); step(); step(); step();
        chk_cnts("after_rst");

        repeat (4) step();
        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
